// File: rtl/neuron_out_buffer.sv
// Output event FIFO between a neuron core and the host: show-ahead read port,
// full back-pressure flag, and a saturating count of events rejected while full.
module neuron_out_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       emit_valid,
    input  logic [7:0]                 emit_data,
    output logic                       have_out,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [7:0]                 drop_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic full, empty, push, pop, drop;

    // Full/empty come from registered occupancy only, so have_out never depends
    // on this cycle's emit_valid or out_ready.
    always_comb begin
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        push  = emit_valid && !full;
        drop  = emit_valid && full;
        pop   = out_ready && !empty;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        drop_count_d = drop_count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is intentionally not reset; the empty gate on out_data hides it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= emit_data;
    end

    always_comb begin
        have_out   = full;
        out_valid  = !empty;
        out_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
        drop_count = drop_count_q;
        level      = level_q;
    end

endmodule
